seq_restore_div: RTL
====================

Name: seq_restore_div

Overview:
- Multi-cycle, parametrised restoring divider: one quotient bit per clock, with a start/busy/done handshake.
- Runs in signed or unsigned mode, selected per operation.
- Flags divide-by-zero and signed overflow.
- Sits beside the ALU. Result is packed quotient-high / remainder-low so it can drive the HI/LO register pair directly.

Parameters:
- WIDTH, 32, operand width in bits; minimum 4.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- busy  out  1  high from the cycle after accepted start until done.
- done  out  1  one-cycle pulse; result and flags valid from this cycle.
- result  out  2*WIDTH  [2W-1:W] = quotient, [W-1:0] = remainder.
- div_by_zero  out  1  sticky until the next accepted start.
- overflow  out  1  signed most-negative / -1 case; sticky until the next accepted start.

Behaviour:
- Reset (async, any time, including mid-operation):
  - State returns to IDLE.
  - busy, done, result, div_by_zero and overflow all go to 0.
  - The in-flight operation is discarded; no done is issued for it.
- States: IDLE -> LOAD -> RUN -> FIX -> IDLE.
- IDLE, start=1:
  - Latch operands and mode; clear both flags; go to LOAD.
  - busy=1 from the next cycle.
- start while busy: ignored; the operation in progress is unaffected.
- LOAD (1 cycle):
  - Form magnitudes: if signed_mode and the MSB is set, take the two's-complement negate; else pass through.
  - Record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend). Both are 0 in unsigned mode.
  - Clear the partial remainder A (WIDTH+1 bits).
  - Load Q with the dividend magnitude and set the iteration counter to WIDTH-1.
  - If divisor==0, go directly to FIX with dbz pending; otherwise go to RUN.
- RUN (exactly WIDTH cycles, one per bit):
  - Shift {A,Q} left by 1.
  - Compute trial = A - {0,divisor_mag} at WIDTH+1 bits.
  - If trial is negative, A is unchanged (restore) and Q[0]=0; else A=trial and Q[0]=1.
  - Decrement the counter; go to FIX after the iteration where the counter is 0.
- FIX (1 cycle), normal case:
  - quotient = q_neg ? -Q : Q.
  - remainder = r_neg ? -A[W-1:0] : A[W-1:0].
  - Truncating semantics: the remainder takes the sign of the dividend.
- FIX, dbz case:
  - quotient = all ones; remainder = original dividend; div_by_zero=1.
- FIX, overflow case (signed_mode, dividend = 100...0, divisor = all ones):
  - quotient = 100...0 (wraps); remainder = 0; overflow=1.
- FIX always:
  - Drive result and pulse done=1 in the cycle after FIX completes.
  - busy drops in that same cycle; return to IDLE.
- Latency, start cycle to done:
  - Normal and overflow: WIDTH+2 cycles (34 for WIDTH=32).
  - dbz: 2 cycles.
- result and flags hold until the next accepted start. They are not cleared at done.
- A start asserted in the same cycle as done is ignored. The FSM is in IDLE only from the following cycle.
- Unsigned mode: operand MSBs are data bits; no negation; overflow is never set.

Test Plan:
- Unsigned 100 / 7 (WIDTH=32) -> after 34 cycles done=1, result = {0x0000000E, 0x00000002}, flags 0, busy high for 33 cycles.
- Signed -7 / 2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7 / -2 -> quotient -3, remainder +1.
- Divisor 0, dividend 0x12345678, either mode -> done after 2 cycles, quotient 0xFFFFFFFF, remainder 0x12345678, div_by_zero=1.
- Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, overflow=1. Same operands unsigned -> quotient 0, remainder 0x80000000, overflow=0.
- Assert start with new operands at cycle 10 of a busy operation -> ignored, first result unchanged. Assert rst at cycle 15 of an operation -> all outputs 0 immediately, no done pulse, next start works normally.
- WIDTH=8 instance, unsigned 255 / 16 -> quotient 15, remainder 15, latency 10 cycles. Random signed/unsigned sweep against a reference model, including divisor=1 and dividend < divisor.

Source files
------------

// File: rtl/seq_restore_div.sv
// Multi-cycle restoring divider producing one quotient bit per clock.
// Supports signed or unsigned operation and flags divide-by-zero and signed overflow.
module seq_restore_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     dividend,
    input  logic [WIDTH-1:0]     divisor,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div_by_zero,
    output logic                 overflow
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FIX
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic                 mode_q, mode_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic [WIDTH-1:0]     dmag_q, dmag_d;
    logic                 q_neg_q, q_neg_d;
    logic                 r_neg_q, r_neg_d;
    logic                 ovf_pend_q, ovf_pend_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 dbz_q, dbz_d;
    logic                 ovf_q, ovf_d;

    logic [WIDTH:0]       shifted;
    logic [WIDTH:0]       trial;
    logic                 q_bit;
    logic [WIDTH:0]       a_next;
    logic [WIDTH-1:0]     q_next;
    logic                 dvd_neg;
    logic                 dvs_neg;
    logic [WIDTH-1:0]     most_neg;

    assign most_neg = {1'b1, {(WIDTH-1){1'b0}}};
    assign dvd_neg  = mode_q & dvd_q[WIDTH-1];
    assign dvs_neg  = mode_q & dvs_q[WIDTH-1];

    // One restoring step: shift {A,Q}, trial-subtract, keep the trial only if non-negative.
    assign shifted = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign trial   = shifted - {1'b0, dmag_q};
    assign q_bit   = ~trial[WIDTH];
    assign a_next  = q_bit ? trial : shifted;
    assign q_next  = {q_q[WIDTH-2:0], q_bit};

    // NOTE: every _d gets its _q value first so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        dvd_d      = dvd_q;
        dvs_d      = dvs_q;
        mode_d     = mode_q;
        a_d        = a_q;
        q_d        = q_q;
        dmag_d     = dmag_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        ovf_pend_d = ovf_pend_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        dbz_d      = dbz_q;
        ovf_d      = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    mode_d  = signed_mode;
                    dbz_d   = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                q_d        = dvd_neg ? -dvd_q : dvd_q;
                dmag_d     = dvs_neg ? -dvs_q : dvs_q;
                a_d        = '0;
                cnt_d      = CW'(WIDTH - 1);
                q_neg_d    = dvd_neg ^ dvs_neg;
                r_neg_d    = dvd_neg;
                ovf_pend_d = mode_q && (dvd_q == most_neg) && (dvs_q == '1);
                if (dvs_q == '0) begin
                    result_d = {{WIDTH{1'b1}}, dvd_q};
                    dbz_d    = 1'b1;
                    state_d  = S_FIX;
                end else begin
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                a_d   = a_next;
                q_d   = q_next;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    // Sign fix-up is folded into the last step so the result is valid with done.
                    result_d = {(q_neg_q ? -q_next : q_next),
                                (r_neg_q ? -a_next[WIDTH-1:0] : a_next[WIDTH-1:0])};
                    ovf_d    = ovf_pend_q;
                    state_d  = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            dvd_q      <= '0;
            dvs_q      <= '0;
            mode_q     <= 1'b0;
            a_q        <= '0;
            q_q        <= '0;
            dmag_q     <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            dvd_q      <= dvd_d;
            dvs_q      <= dvs_d;
            mode_q     <= mode_d;
            a_q        <= a_d;
            q_q        <= q_d;
            dmag_q     <= dmag_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            ovf_pend_q <= ovf_pend_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            dbz_q      <= dbz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy        = (state_q == S_LOAD) || (state_q == S_RUN);
    assign done        = (state_q == S_FIX);
    assign result      = result_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovf_q;

endmodule
